// File: rtl/temp_flag_gen_pkg.sv
// Shared types and defaults for the temperature flag front end:
// band encoding, default thresholds/filter lengths and the sensor fault code.
package temp_pkg;

  typedef enum logic [1:0] {
    FRIO = 2'd0,
    B25  = 2'd1,
    B27  = 2'd2,
    B30  = 2'd3
  } band_t;

  localparam int DEF_TW      = 8;
  localparam int DEF_TH25    = 25;
  localparam int DEF_TH27    = 27;
  localparam int DEF_TH30    = 30;
  localparam int DEF_HYST    = 1;
  localparam int DEF_PERSIST = 4;
  localparam int DEF_DEB     = 16;

  // The sensor reports a fault by sending an all-ones sample of its width.
  function automatic logic is_fault(input logic [31:0] sample, input int width);
    logic [31:0] ones;
    ones = (32'd1 << width) - 32'd1;
    return sample == ones;
  endfunction

endpackage

// File: rtl/temp_flag_gen_if.sv
// Sensor-side bundle: strobed temperature sample and raw presence in,
// band flags, debounced presence and sensor error out.
interface temp_flag_gen_if
  import temp_pkg::*;
#(
  parameter int TW = DEF_TW
);

  logic [TW-1:0] temp;
  logic          temp_vld;
  logic          corp_raw;
  logic          t_25;
  logic          t_27;
  logic          t_30;
  logic          t_corp;
  logic          sens_err;

  modport master (
    output temp, temp_vld, corp_raw,
    input  t_25, t_27, t_30, t_corp, sens_err
  );

  modport slave (
    input  temp, temp_vld, corp_raw,
    output t_25, t_27, t_30, t_corp, sens_err
  );

endinterface

// File: rtl/temp_flag_gen_sync_debounce.sv
// Two-flop synchronizer followed by a debounce counter; the output only
// follows the input after it has disagreed for DEB consecutive clocks.
module sync_debounce #(
  parameter int DEB = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEB + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Synchronize, then count clocks of disagreement and toggle on the DEB-th.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != stable) begin
        if (cnt == CW'(DEB - 1)) begin
          stable <= ~stable;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/temp_flag_gen.sv
// Converts strobed temperature samples into mutually exclusive band flags
// with downward hysteresis and persistence filtering, and debounces presence.
module temp_flag_gen
  import temp_pkg::*;
#(
  parameter int TW      = DEF_TW,
  parameter int TH25    = DEF_TH25,
  parameter int TH27    = DEF_TH27,
  parameter int TH30    = DEF_TH30,
  parameter int HYST    = DEF_HYST,
  parameter int PERSIST = DEF_PERSIST,
  parameter int DEB     = DEF_DEB
) (
  input logic           clk,
  input logic           reset,
  temp_flag_gen_if.slave bus
);

  localparam logic [TW:0] TH25_X = (TW + 1)'(TH25);
  localparam logic [TW:0] TH27_X = (TW + 1)'(TH27);
  localparam logic [TW:0] TH30_X = (TW + 1)'(TH30);
  localparam logic [TW:0] HYST_X = (TW + 1)'(HYST);
  localparam logic [TW:0] LO25   = (TH25_X >= HYST_X) ? TH25_X - HYST_X : '0;
  localparam logic [TW:0] LO27   = (TH27_X >= HYST_X) ? TH27_X - HYST_X : '0;
  localparam logic [TW:0] LO30   = (TH30_X >= HYST_X) ? TH30_X - HYST_X : '0;

  band_t       state;
  band_t       pending;
  band_t       up;
  band_t       cand;
  logic [3:0]  pcnt;
  logic [3:0]  pcnt_nxt;
  logic [TW:0] temp_x;
  logic        fault;

  assign temp_x = {1'b0, bus.temp};
  assign fault  = is_fault(32'(bus.temp), TW);

  // Candidate band: rise straight to the highest reached band, otherwise
  // hold the highest band at or below the current one still within hysteresis.
  always_comb begin
    up = FRIO;
    if (temp_x >= TH25_X) up = B25;
    if (temp_x >= TH27_X) up = B27;
    if (temp_x >= TH30_X) up = B30;
    cand = FRIO;
    if (up > state) begin
      cand = up;
    end else begin
      if (state >= B25 && temp_x >= LO25) cand = B25;
      if (state >= B27 && temp_x >= LO27) cand = B27;
      if (state == B30 && temp_x >= LO30) cand = B30;
    end
  end

  // Next persistence count: extend a run of the same candidate or start anew.
  always_comb begin
    pcnt_nxt = 4'd1;
    if (cand == pending) pcnt_nxt = pcnt + 4'd1;
  end

  // Band FSM: fault samples only flag the error, other samples feed the filter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FRIO;
      pending  <= FRIO;
      pcnt     <= 4'd0;
      bus.sens_err <= 1'b0;
    end else if (bus.temp_vld) begin
      if (fault) begin
        bus.sens_err <= 1'b1;
      end else begin
        bus.sens_err <= 1'b0;
        if (cand == state) begin
          pcnt <= 4'd0;
        end else begin
          pending <= cand;
          if (pcnt_nxt == 4'(PERSIST)) begin
            state <= cand;
            pcnt  <= 4'd0;
          end else begin
            pcnt <= pcnt_nxt;
          end
        end
      end
    end
  end

  assign bus.t_25 = (state == B25);
  assign bus.t_27 = (state == B27);
  assign bus.t_30 = (state == B30);

  sync_debounce #(
    .DEB(DEB)
  ) u_presence (
    .clk    (clk),
    .reset  (reset),
    .raw    (bus.corp_raw),
    .stable (bus.t_corp)
  );

endmodule

// File: tb/tb_temp_flag_gen.sv
// Randomized and directed bench for temp_flag_gen with a scoreboard queue fed
// by a behavioural band/presence model and drained by a per-cycle monitor.
module tb_temp_flag_gen;
  import temp_pkg::*;

  localparam int PERSIST = 4;
  localparam int DEB     = 16;
  localparam int HYST    = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  temp_flag_gen_if #(.TW(8)) bus ();

  temp_flag_gen #(
    .TW(8), .TH25(25), .TH27(27), .TH30(30),
    .HYST(HYST), .PERSIST(PERSIST), .DEB(DEB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int band;
    bit serr;
    bit corp;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;
  bit   corpLevel = 1'b0;

  // Reference model state: current band, error flag, presence and its filters.
  int   mBand;
  bit   mSerr;
  bit   mCorp;
  int   mRun;
  bit   rawQ[$];
  int   candRun[$];
  int   th[4] = '{0, 25, 27, 30};

  function automatic int candidateOf(int t, int cur);
    int up;
    int lo;
    up = 0;
    for (int b = 1; b <= 3; b++) if (t >= th[b]) up = b;
    if (up > cur) return up;
    for (int b = cur; b >= 1; b--) begin
      lo = th[b] - HYST;
      if (lo < 0) lo = 0;
      if (t >= lo) return b;
    end
    return 0;
  endfunction

  task automatic modelReset();
    mBand = 0;
    mSerr = 1'b0;
    mCorp = 1'b0;
    mRun  = 0;
    rawQ.delete();
    rawQ.push_back(1'b0);
    rawQ.push_back(1'b0);
    candRun.delete();
  endtask

  // Advance the model by one clock edge and queue the expected outputs.
  task automatic modelStep(int t, bit v, bit r);
    exp_t e;
    int   c;
    bit   seen;
    seen = rawQ.pop_front();
    rawQ.push_back(r);
    if (seen != mCorp) begin
      mRun++;
      if (mRun == DEB) begin
        mCorp = ~mCorp;
        mRun  = 0;
      end
    end else begin
      mRun = 0;
    end
    if (v) begin
      if (t == 255) begin
        mSerr = 1'b1;
      end else begin
        mSerr = 1'b0;
        c = candidateOf(t, mBand);
        if (c == mBand) begin
          candRun.delete();
        end else begin
          if (candRun.size() > 0 && candRun[$] != c) candRun.delete();
          candRun.push_back(c);
          if (candRun.size() == PERSIST) begin
            mBand = c;
            candRun.delete();
          end
        end
      end
    end
    e.band = mBand;
    e.serr = mSerr;
    e.corp = mCorp;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(int t, bit v, bit r);
    @(negedge clk);
    bus.temp     = 8'(t);
    bus.temp_vld = v;
    bus.corp_raw = r;
    modelStep(t, v, r);
  endtask

  task automatic checkOutput(exp_t e);
    logic [2:0] got;
    logic [2:0] want;
    got  = {bus.t_30, bus.t_27, bus.t_25};
    want = (e.band == 0) ? 3'b000 : 3'(1 << (e.band - 1));
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL flags got=%b want=%b at %0t", got, want, $time);
    end
    total++;
    if (bus.sens_err !== e.serr) begin
      bad++;
      $display("[TB] FAIL sens_err got=%b want=%b at %0t", bus.sens_err, e.serr, $time);
    end
    total++;
    if (bus.t_corp !== e.corp) begin
      bad++;
      $display("[TB] FAIL t_corp got=%b want=%b at %0t", bus.t_corp, e.corp, $time);
    end
  endtask

  // Monitor: one expectation per driven cycle, checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic checkZero(string name, logic val);
    total++;
    if (val !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_%s got=%b want=0 at %0t", name, val, $time);
    end
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic applyReset();
    @(negedge clk);
    reset        = 1'b1;
    bus.temp_vld = 1'b0;
    bus.corp_raw = 1'b0;
    #1;
    checkZero("t_25", bus.t_25);
    checkZero("t_27", bus.t_27);
    checkZero("t_30", bus.t_30);
    checkZero("t_corp", bus.t_corp);
    checkZero("sens_err", bus.sens_err);
    modelReset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    modelStep(0, 1'b0, 1'b0);
  endtask

  task automatic sendTemp(int t, int n);
    repeat (n) applyStimulus(t, 1'b1, corpLevel);
  endtask

  task automatic idle(int n);
    repeat (n) applyStimulus(0, 1'b0, corpLevel);
  endtask

  initial begin
    int base;
    int t;
    bit v;
    bus.temp     = '0;
    bus.temp_vld = 1'b0;
    bus.corp_raw = 1'b0;
    modelReset();
    applyReset();

    // Rise from 20 degrees through B25 straight to B30.
    sendTemp(20, 3);
    sendTemp(26, 4);
    idle(2);
    sendTemp(31, 4);
    idle(2);
    corpLevel = 1'b1;
    idle(22);
    applyReset();

    // Hysteresis holds B27 at 26, then drops to B25 at 25.
    corpLevel = 1'b0;
    sendTemp(28, 4);
    sendTemp(26, 8);
    sendTemp(25, 4);
    idle(2);
    applyReset();

    // Persistence run broken by an in-band sample.
    sendTemp(28, 3);
    sendTemp(24, 1);
    sendTemp(28, 4);
    idle(2);
    applyReset();

    // Fault code inside a run, with idle gaps.
    sendTemp(26, 2);
    sendTemp(255, 1);
    idle(1);
    sendTemp(26, 2);
    idle(2);
    sendTemp(26, 1);
    idle(2);

    // Presence glitch, long high, long low.
    corpLevel = 1'b1;
    idle(10);
    corpLevel = 1'b0;
    idle(10);
    corpLevel = 1'b1;
    idle(25);
    corpLevel = 1'b0;
    idle(25);

    // Randomized wandering temperature with faults and presence changes.
    base = 22;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) base = int'($urandom_range(18, 34));
      if ($urandom_range(0, 29) == 0) corpLevel = ~corpLevel;
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) t = 255;
      else t = base + int'($urandom_range(0, 2)) - 1;
      applyStimulus(t, v, corpLevel);
    end
    idle(3);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
